// File: rtl/sel_enc_pkg.sv
// Shared defaults, select-source enum and one-hot helper for the register select/encode block.
package sel_enc_pkg;

  localparam int DEF_NUM_REGS = 16;
  localparam int DEF_IDX_W    = 4;
  localparam int DEF_IMM_W    = 19;
  localparam int DEF_DATA_W   = 32;
  localparam int MAX_REGS     = 256;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_RA,
    SEL_RB,
    SEL_RC
  } sel_src_e;

  // Indices past MAX_REGS shift out to an all-zero mask; callers narrow with a size cast.
  function automatic logic [MAX_REGS-1:0] onehot(input int unsigned idx);
    onehot = MAX_REGS'(1) << idx;
  endfunction

endpackage

// File: rtl/reg_select_scoreboard_if.sv
// Control-unit <-> register-select bus. The imm_zext field exists only when SEL_ENC_ZEXT_EN is defined.
interface reg_select_scoreboard_if
  import sel_enc_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int IDX_W    = DEF_IDX_W,
  parameter int IMM_W    = DEF_IMM_W,
  parameter int DATA_W   = DEF_DATA_W
);
  logic                issue_valid;
  logic                Gra, Grb, Grc;
  logic                Rin, Rout, BAout;
  logic                reserve;
  logic [IDX_W-1:0]    Ra, Rb, Rc;
  logic [IMM_W-1:0]    C;
  logic                wb_valid;
  logic [IDX_W-1:0]    wb_idx;
`ifdef SEL_ENC_ZEXT_EN
  logic                imm_zext;
`endif
  logic [NUM_REGS-1:0] RinSignals;
  logic [NUM_REGS-1:0] RoutSignals;
  logic                ba_zero;
  logic [DATA_W-1:0]   C_sign_extended;
  logic                stall;
  logic                idx_err;
  logic [NUM_REGS-1:0] busy_vec;

  modport master (
    output issue_valid, Gra, Grb, Grc, Rin, Rout, BAout, reserve,
    output Ra, Rb, Rc, C, wb_valid, wb_idx,
`ifdef SEL_ENC_ZEXT_EN
    output imm_zext,
`endif
    input  RinSignals, RoutSignals, ba_zero, C_sign_extended, stall, idx_err, busy_vec
  );

  modport slave (
    input  issue_valid, Gra, Grb, Grc, Rin, Rout, BAout, reserve,
    input  Ra, Rb, Rc, C, wb_valid, wb_idx,
`ifdef SEL_ENC_ZEXT_EN
    input  imm_zext,
`endif
    output RinSignals, RoutSignals, ba_zero, C_sign_extended, stall, idx_err, busy_vec
  );
endinterface

// File: rtl/sel_enc_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, released by write-back, set by reservations.
module sel_enc_scoreboard
  import sel_enc_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int IDX_W    = DEF_IDX_W
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                wb_valid,
  input  logic [IDX_W-1:0]    wb_idx,
  input  logic                set_valid,
  input  logic [IDX_W-1:0]    set_idx,
  input  logic [IDX_W-1:0]    query_idx,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                hazard
);
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] clr_mask, set_mask, query_mask, busy_eff;

  always_comb begin
    clr_mask   = wb_valid  ? NUM_REGS'(onehot(32'(wb_idx)))  : '0;
    set_mask   = set_valid ? NUM_REGS'(onehot(32'(set_idx))) : '0;
    query_mask = NUM_REGS'(onehot(32'(query_idx)));
    // Same-cycle write-back is visible to the hazard check (bypass).
    busy_eff   = busy_q & ~clr_mask;
    hazard     = |(busy_eff & query_mask);
    busy_d     = busy_eff | set_mask;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_vec = busy_q;
endmodule

// File: rtl/reg_select_scoreboard.sv
// Register select/encode with registered one-hot strobes, constant extender and hazard stall.
// Optional SEL_ENC_ZEXT_EN adds bus.imm_zext to zero-extend the constant.
module reg_select_scoreboard
  import sel_enc_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int IDX_W    = DEF_IDX_W,
  parameter int IMM_W    = DEF_IMM_W,
  parameter int DATA_W   = DEF_DATA_W
) (
  input  logic clock,
  input  logic clear,
  reg_select_scoreboard_if.slave bus
);
  sel_src_e            sel_src;
  logic [IDX_W-1:0]    sel_idx;
  logic                in_range, active, ba_r0, hazard, set_valid;
  logic [NUM_REGS-1:0] sel_mask;

  logic [NUM_REGS-1:0] rin_q, rin_d, rout_q, rout_d;
  logic                ba_zero_q, ba_zero_d, stall_q, stall_d, idx_err_q, idx_err_d;
  logic [DATA_W-1:0]   c_ext_q, c_ext_d;

  always_comb begin
    sel_src = SEL_NONE;
    sel_idx = '0;
    if (bus.Gra) begin
      sel_src = SEL_RA;
      sel_idx = bus.Ra;
    end else if (bus.Grb) begin
      sel_src = SEL_RB;
      sel_idx = bus.Rb;
    end else if (bus.Grc) begin
      sel_src = SEL_RC;
      sel_idx = bus.Rc;
    end
  end

  always_comb begin
    in_range = 32'(sel_idx) < 32'(NUM_REGS);
    sel_mask = NUM_REGS'(onehot(32'(sel_idx)));
    active   = bus.issue_valid && (sel_src != SEL_NONE) && (bus.Rin || bus.Rout || bus.BAout);
    // R0 as a base address means literal zero, so it never depends on a pending write.
    ba_r0    = !bus.Rin && bus.BAout && (sel_idx == '0);
  end

  sel_enc_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_scoreboard (
    .clock     (clock),
    .clear     (clear),
    .wb_valid  (bus.wb_valid),
    .wb_idx    (bus.wb_idx),
    .set_valid (set_valid),
    .set_idx   (sel_idx),
    .query_idx (sel_idx),
    .busy_vec  (bus.busy_vec),
    .hazard    (hazard)
  );

  always_comb begin
    rin_d     = '0;
    rout_d    = '0;
    ba_zero_d = 1'b0;
    stall_d   = 1'b0;
    idx_err_d = 1'b0;
    set_valid = 1'b0;
    if (active) begin
      if (!in_range) begin
        idx_err_d = 1'b1;
      end else if (ba_r0) begin
        ba_zero_d = 1'b1;
      end else if (hazard) begin
        stall_d = 1'b1;
      end else if (bus.Rin) begin
        rin_d     = sel_mask;
        set_valid = bus.reserve;
      end else begin
        rout_d = sel_mask;
      end
    end
  end

  always_comb begin
    c_ext_d = c_ext_q;
    if (bus.issue_valid) begin
`ifdef SEL_ENC_ZEXT_EN
      if (bus.imm_zext) c_ext_d = {{(DATA_W-IMM_W){1'b0}}, bus.C};
      else              c_ext_d = {{(DATA_W-IMM_W){bus.C[IMM_W-1]}}, bus.C};
`else
      c_ext_d = {{(DATA_W-IMM_W){bus.C[IMM_W-1]}}, bus.C};
`endif
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      rin_q     <= '0;
      rout_q    <= '0;
      ba_zero_q <= 1'b0;
      stall_q   <= 1'b0;
      idx_err_q <= 1'b0;
      c_ext_q   <= '0;
    end else begin
      rin_q     <= rin_d;
      rout_q    <= rout_d;
      ba_zero_q <= ba_zero_d;
      stall_q   <= stall_d;
      idx_err_q <= idx_err_d;
      c_ext_q   <= c_ext_d;
    end
  end

  assign bus.RinSignals      = rin_q;
  assign bus.RoutSignals     = rout_q;
  assign bus.ba_zero         = ba_zero_q;
  assign bus.stall           = stall_q;
  assign bus.idx_err         = idx_err_q;
  assign bus.C_sign_extended = c_ext_q;
endmodule

// File: tb/tb_reg_select_scoreboard.sv
// Directed bench for reg_select_scoreboard: a 16-register instance plus an 8-register one for idx_err.
module tb_reg_select_scoreboard;
  logic clock = 1'b0;
  logic clear = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clock = ~clock;

  reg_select_scoreboard_if #(.NUM_REGS(16)) bus ();
  reg_select_scoreboard_if #(.NUM_REGS(8))  bus8 ();

  reg_select_scoreboard #(.NUM_REGS(16)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  reg_select_scoreboard #(.NUM_REGS(8)) dut8 (
    .clock (clock),
    .clear (clear),
    .bus   (bus8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("[TB] %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.issue_valid = 0; bus.Gra = 0; bus.Grb = 0; bus.Grc = 0;
    bus.Rin = 0; bus.Rout = 0; bus.BAout = 0; bus.reserve = 0;
    bus.Ra = '0; bus.Rb = '0; bus.Rc = '0;
    bus.wb_valid = 0; bus.wb_idx = '0;
`ifdef SEL_ENC_ZEXT_EN
    bus.imm_zext = 0;
`endif
  endtask

  task automatic idle8();
    bus8.issue_valid = 0; bus8.Gra = 0; bus8.Grb = 0; bus8.Grc = 0;
    bus8.Rin = 0; bus8.Rout = 0; bus8.BAout = 0; bus8.reserve = 0;
    bus8.Ra = '0; bus8.Rb = '0; bus8.Rc = '0; bus8.C = '0;
    bus8.wb_valid = 0; bus8.wb_idx = '0;
`ifdef SEL_ENC_ZEXT_EN
    bus8.imm_zext = 0;
`endif
  endtask

  initial begin
    idle();
    idle8();
    bus.C = 19'h7FFFF;
    #2;
    check("reset_rin",   32'(bus.RinSignals), 32'h0);
    check("reset_rout",  32'(bus.RoutSignals), 32'h0);
    check("reset_cext",  bus.C_sign_extended, 32'h0);
    check("reset_busy",  32'(bus.busy_vec), 32'h0);
    check("reset_flags", {29'd0, bus.ba_zero, bus.stall, bus.idx_err}, 32'h0);
    #10 clear = 1'b1;
    tick();

    // Write R5 via Ra
    bus.issue_valid = 1; bus.Gra = 1; bus.Ra = 4'd5; bus.Rin = 1; bus.C = 19'h00000;
    tick();
    check("w_r5_rin",   32'(bus.RinSignals), 32'h0020);
    check("w_r5_rout",  32'(bus.RoutSignals), 32'h0);
    check("w_r5_stall", 32'(bus.stall), 32'h0);
    idle();
    tick();
    check("w_r5_drop", 32'(bus.RinSignals), 32'h0);

    // Priority: Gra beats Grb, Rin beats Rout
    bus.issue_valid = 1; bus.Gra = 1; bus.Grb = 1; bus.Ra = 4'd2; bus.Rb = 4'd9;
    bus.Rin = 1; bus.Rout = 1;
    tick();
    check("prio_rin",  32'(bus.RinSignals), 32'h0004);
    check("prio_rout", 32'(bus.RoutSignals), 32'h0);
    idle();

    // Rc read, and no field select gives nothing
    bus.issue_valid = 1; bus.Grc = 1; bus.Rc = 4'd15; bus.Rout = 1;
    tick();
    check("rc_rout", 32'(bus.RoutSignals), 32'h8000);
    bus.Grc = 0;
    tick();
    check("nosel_rout",  32'(bus.RoutSignals), 32'h0);
    check("nosel_stall", 32'(bus.stall), 32'h0);
    idle();

    // BAout on R0 reads constant zero; Rout on R0 is a normal read
    bus.issue_valid = 1; bus.Grb = 1; bus.Rb = 4'd0; bus.BAout = 1;
    tick();
    check("ba_r0_rout", 32'(bus.RoutSignals), 32'h0);
    check("ba_r0_zero", 32'(bus.ba_zero), 32'h1);
    bus.BAout = 0; bus.Rout = 1;
    tick();
    check("rout_r0_rout", 32'(bus.RoutSignals), 32'h0001);
    check("rout_r0_zero", 32'(bus.ba_zero), 32'h0);
    bus.Rb = 4'd6; bus.Rout = 0; bus.BAout = 1;
    tick();
    check("ba_r6_rout", 32'(bus.RoutSignals), 32'h0040);
    idle();

    // Constant extension and hold
    bus.issue_valid = 1; bus.C = 19'h40000;
    tick();
    check("cext_neg", bus.C_sign_extended, 32'hFFFC0000);
    bus.C = 19'h00123;
    tick();
    check("cext_pos", bus.C_sign_extended, 32'h00000123);
    bus.issue_valid = 0; bus.C = 19'h40000;
    tick();
    check("cext_hold", bus.C_sign_extended, 32'h00000123);
`ifdef SEL_ENC_ZEXT_EN
    bus.issue_valid = 1; bus.imm_zext = 1;
    tick();
    check("cext_zext", bus.C_sign_extended, 32'h00040000);
`endif
    idle();

    // Reserve R7, then RAW and WAW stall, then write-back bypass
    bus.issue_valid = 1; bus.Gra = 1; bus.Ra = 4'd7; bus.Rin = 1; bus.reserve = 1;
    tick();
    check("rsv7_rin",  32'(bus.RinSignals), 32'h0080);
    check("rsv7_busy", 32'(bus.busy_vec), 32'h0080);
    bus.Rin = 0; bus.reserve = 0; bus.Rout = 1;
    tick();
    check("raw7_stall", 32'(bus.stall), 32'h1);
    check("raw7_rout",  32'(bus.RoutSignals), 32'h0);
    bus.Rout = 0; bus.Rin = 1;
    tick();
    check("waw7_stall", 32'(bus.stall), 32'h1);
    check("waw7_rin",   32'(bus.RinSignals), 32'h0);
    bus.Rin = 0; bus.Rout = 1; bus.wb_valid = 1; bus.wb_idx = 4'd7;
    tick();
    check("byp7_rout",  32'(bus.RoutSignals), 32'h0080);
    check("byp7_stall", 32'(bus.stall), 32'h0);
    check("byp7_busy",  32'(bus.busy_vec), 32'h0);
    idle();

    // Set wins over clear on the same index; stray write-back ignored
    bus.issue_valid = 1; bus.Gra = 1; bus.Ra = 4'd3; bus.Rin = 1; bus.reserve = 1;
    tick();
    check("rsv3_busy", 32'(bus.busy_vec), 32'h0008);
    bus.wb_valid = 1; bus.wb_idx = 4'd3;
    tick();
    check("setclr3_rin",  32'(bus.RinSignals), 32'h0008);
    check("setclr3_busy", 32'(bus.busy_vec), 32'h0008);
    idle();
    bus.wb_valid = 1; bus.wb_idx = 4'd3;
    tick();
    check("wb3_busy", 32'(bus.busy_vec), 32'h0);
    bus.wb_idx = 4'd9;
    tick();
    check("wb_stray_busy", 32'(bus.busy_vec), 32'h0);
    idle();

    // Out-of-range index on the 8-register instance
    bus8.issue_valid = 1; bus8.Gra = 1; bus8.Ra = 4'd9; bus8.Rin = 1; bus8.reserve = 1;
    tick();
    check("idx9_err",  32'(bus8.idx_err), 32'h1);
    check("idx9_rin",  32'(bus8.RinSignals), 32'h0);
    check("idx9_rout", 32'(bus8.RoutSignals), 32'h0);
    check("idx9_busy", 32'(bus8.busy_vec), 32'h0);
    bus8.Ra = 4'd7;
    tick();
    check("idx7_err", 32'(bus8.idx_err), 32'h0);
    check("idx7_rin", 32'(bus8.RinSignals), 32'h80);
    idle8();

    // Reserve R2 and R4, then asynchronous clear mid-cycle
    bus.issue_valid = 1; bus.Gra = 1; bus.Ra = 4'd2; bus.Rin = 1; bus.reserve = 1;
    tick();
    bus.Ra = 4'd4;
    tick();
    check("rsv24_busy", 32'(bus.busy_vec), 32'h0014);
    check("rsv24_rin",  32'(bus.RinSignals), 32'h0010);
    idle();
    #2 clear = 1'b0;
    #1;
    check("aclr_busy", 32'(bus.busy_vec), 32'h0);
    check("aclr_rin",  32'(bus.RinSignals), 32'h0);
    check("aclr_busy8", 32'(bus8.busy_vec), 32'h0);
    check("aclr_cext", bus.C_sign_extended, 32'h0);
    #10 clear = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
